// File: rtl/vga_board_capture_pkg.sv
// Shared timing constants, token/board types and the receiver FSM states for the
// VGA board capture path.
package vga_pkg;

  localparam int unsigned VGA_H_TOTAL  = 800;
  localparam int unsigned VGA_V_TOTAL  = 525;
  localparam int unsigned VGA_H_OFFSET = 144;
  localparam int unsigned VGA_V_OFFSET = 35;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_GRID_X0  = 40;
  localparam int unsigned VGA_GRID_Y0  = 30;
  localparam int unsigned VGA_CELL_W   = 80;
  localparam int unsigned VGA_CELL_H   = 70;
  localparam logic [7:0]  VGA_THRESH   = 8'd128;

  localparam int unsigned ROWS = 6;
  localparam int unsigned COLS = 7;
  localparam int unsigned HCW  = 11;
  localparam int unsigned VCW  = 10;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } token_t;

  // Bit-plane layout: [bit][row][col].
  typedef logic [1:0][0:ROWS-1][0:COLS-1] board_t;

  typedef enum logic [1:0] {
    SEARCH,
    ALIGN,
    LOCKED
  } rx_state_t;

  function automatic token_t classify(input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b, input logic [7:0] th);
    logic rh, gh, bh;
    rh = (r >= th);
    gh = (g >= th);
    bh = (b >= th);
    if (rh && gh && !bh) return P2;
    if (rh && !gh && !bh) return P1;
    return EMPTY;
  endfunction

endpackage

// File: rtl/vga_board_capture_if.sv
// VGA stream bundle: sync strobes plus RGB, driven by the controller (master)
// and observed by the capture block (slave).
interface vga_board_capture_if;
  logic       h_sync;
  logic       v_sync;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;

  modport master (output h_sync, v_sync, red, green, blue);
  modport slave  (input  h_sync, v_sync, red, green, blue);
endinterface

// File: rtl/vga_board_capture_sync_tracker.sv
// Sync recovery: input registers, edge detect, h/v counters, period checks and the
// lock FSM. Emits aligned pixel data with x/y coordinates and frame strobes.
module vga_sync_tracker
  import vga_pkg::*;
#(
  parameter int unsigned H_TOTAL  = VGA_H_TOTAL,
  parameter int unsigned V_TOTAL  = VGA_V_TOTAL,
  parameter int unsigned H_OFFSET = VGA_H_OFFSET,
  parameter int unsigned V_OFFSET = VGA_V_OFFSET,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE
) (
  input  logic               clk_25mhz,
  input  logic               reset_n,
  vga_board_capture_if.slave vga,
  output logic [9:0]         x,
  output logic [9:0]         y,
  output logic               pix_valid,
  output logic [7:0]         px_red,
  output logic [7:0]         px_green,
  output logic [7:0]         px_blue,
  output logic               frame_edge,
  output logic               frame_clean,
  output logic               locked,
  output logic               sync_err
);

  localparam logic [HCW-1:0] H_LAST    = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_TIMEOUT = HCW'(2 * H_TOTAL);
  localparam logic [HCW-1:0] H_X0      = HCW'(H_OFFSET);
  localparam logic [HCW-1:0] H_X1      = HCW'(H_OFFSET + H_ACTIVE);
  localparam logic [VCW-1:0] V_END     = VCW'(V_TOTAL);
  localparam logic [VCW-1:0] V_Y0      = VCW'(V_OFFSET);
  localparam logic [VCW-1:0] V_Y1      = VCW'(V_OFFSET + V_ACTIVE);

  logic           hs_q, hs_d, vs_q, vs_d;
  logic [7:0]     r_q, g_q, b_q;
  logic           hs_fall, vs_fall, viol;
  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;
  rx_state_t      state;

  // RGB gets a second stage so that px_* lines up with the index h_cnt reports.
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      hs_q <= 1'b1;  hs_d <= 1'b1;
      vs_q <= 1'b1;  vs_d <= 1'b1;
      r_q  <= '0;    g_q  <= '0;    b_q  <= '0;
      px_red <= '0;  px_green <= '0; px_blue <= '0;
    end else begin
      hs_q <= vga.h_sync;  hs_d <= hs_q;
      vs_q <= vga.v_sync;  vs_d <= vs_q;
      r_q  <= vga.red;     g_q  <= vga.green;  b_q <= vga.blue;
      px_red <= r_q;       px_green <= g_q;    px_blue <= b_q;
    end
  end

  always_comb begin
    hs_fall = hs_d & ~hs_q;
    vs_fall = vs_d & ~vs_q;
    viol    = (state != SEARCH) &&
              ((hs_fall && (h_cnt != H_LAST)) ||
               (vs_fall && (v_cnt != V_END))  ||
               (h_cnt >= H_TIMEOUT));
    x         = 10'(h_cnt - H_X0);
    y         = 10'(v_cnt - V_Y0);
    pix_valid = (h_cnt >= H_X0) && (h_cnt < H_X1) && (v_cnt >= V_Y0) && (v_cnt < V_Y1);
  end

  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      if (hs_fall) h_cnt <= '0;
      else if (h_cnt != '1) h_cnt <= h_cnt + 1'b1;
      // A coincident hsync fall counts as the first line of the new frame.
      if (vs_fall) v_cnt <= hs_fall ? VCW'(1) : '0;
      else if (hs_fall && (v_cnt != '1)) v_cnt <= v_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SEARCH;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      frame_edge  <= 1'b0;
      frame_clean <= 1'b0;
    end else begin
      sync_err   <= 1'b0;
      frame_edge <= 1'b0;
      case (state)
        SEARCH: if (vs_fall) state <= ALIGN;
        ALIGN, LOCKED: begin
          if (viol) begin
            state       <= SEARCH;
            locked      <= 1'b0;
            sync_err    <= 1'b1;
            frame_clean <= 1'b0;
          end else if (vs_fall) begin
            state       <= LOCKED;
            locked      <= 1'b1;
            frame_edge  <= 1'b1;
            frame_clean <= (state == LOCKED);
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: rtl/vga_board_capture.sv
// Captures the 6x7 board from a looped-back VGA stream and publishes it once per
// clean frame. Optional VGA_RX_DEBOUNCE_EN: publish only when two frames agree.
module vga_board_capture
  import vga_pkg::*;
#(
  parameter int unsigned H_TOTAL  = VGA_H_TOTAL,
  parameter int unsigned V_TOTAL  = VGA_V_TOTAL,
  parameter int unsigned H_OFFSET = VGA_H_OFFSET,
  parameter int unsigned V_OFFSET = VGA_V_OFFSET,
  parameter int unsigned GRID_X0  = VGA_GRID_X0,
  parameter int unsigned GRID_Y0  = VGA_GRID_Y0,
  parameter int unsigned CELL_W   = VGA_CELL_W,
  parameter int unsigned CELL_H   = VGA_CELL_H,
  parameter logic [7:0]  THRESH   = VGA_THRESH
) (
  input  logic               clk_25mhz,
  input  logic               reset_n,
  vga_board_capture_if.slave vga,
  output board_t             tablero_out,
  output logic               frame_done,
  output logic               locked,
  output logic               sync_err,
  output logic [7:0]         frame_cnt
);

  logic [9:0] x, y;
  logic       pix_valid;
  logic [7:0] px_red, px_green, px_blue;
  logic       frame_edge, frame_clean;
  token_t     tok;
  board_t     shadow;
  logic       publish_ok;

  vga_sync_tracker #(
    .H_TOTAL  (H_TOTAL),
    .V_TOTAL  (V_TOTAL),
    .H_OFFSET (H_OFFSET),
    .V_OFFSET (V_OFFSET),
    .H_ACTIVE (VGA_H_ACTIVE),
    .V_ACTIVE (VGA_V_ACTIVE)
  ) u_sync (
    .clk_25mhz   (clk_25mhz),
    .reset_n     (reset_n),
    .vga         (vga),
    .x           (x),
    .y           (y),
    .pix_valid   (pix_valid),
    .px_red      (px_red),
    .px_green    (px_green),
    .px_blue     (px_blue),
    .frame_edge  (frame_edge),
    .frame_clean (frame_clean),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always_comb tok = classify(px_red, px_green, px_blue, THRESH);

  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= '0;
    end else if (sync_err) begin
      shadow <= '0;
    end else if (pix_valid) begin
      for (int unsigned r = 0; r < ROWS; r++)
        for (int unsigned c = 0; c < COLS; c++)
          if ((y == 10'(GRID_Y0 + r * CELL_H + CELL_H / 2)) &&
              (x == 10'(GRID_X0 + c * CELL_W + CELL_W / 2))) begin
            shadow[1][3'(r)][3'(c)] <= tok[1];
            shadow[0][3'(r)][3'(c)] <= tok[0];
          end
    end
  end

`ifdef VGA_RX_DEBOUNCE_EN
  board_t shadow_prev;

  // The compare copy also tracks the measure-only frame so the first locked frame can publish.
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n)        shadow_prev <= '0;
    else if (sync_err)   shadow_prev <= '0;
    else if (frame_edge) shadow_prev <= shadow;
  end

  always_comb publish_ok = (shadow == shadow_prev);
`else
  always_comb publish_ok = 1'b1;
`endif

  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      tablero_out <= '0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_done <= 1'b0;
      if (frame_edge && frame_clean && publish_ok) begin
        tablero_out <= shadow;
        frame_done  <= 1'b1;
        frame_cnt   <= frame_cnt + 8'd1;
      end
    end
  end

endmodule
